// File: rtl/cva6_lsu_mem_pkg.sv
// Shared types and constants for the LSU memory-side responder.
// Contents:
//   MAX_LATENCY  largest latency the 4-bit age counters can represent
//   AGE_W        width of a queue entry's age counter
//   mem_req_t    request as seen on the LSU request interface
//   resp_entry_t one queue slot: address plus age
//   age_inc()    saturating age increment
package cva6_lsu_mem_pkg;

  localparam int unsigned MAX_LATENCY = 15;
  localparam int unsigned AGE_W       = 4;
  localparam int unsigned PKG_ADDR_W  = 32;

  typedef struct packed {
    logic                  is_load;
    logic [PKG_ADDR_W-1:0] addr;
  } mem_req_t;

  typedef struct packed {
    logic [PKG_ADDR_W-1:0] addr;
    logic [AGE_W-1:0]      age;
  } resp_entry_t;

  function automatic logic [AGE_W-1:0] age_inc(input logic [AGE_W-1:0] age,
                                               input logic [AGE_W-1:0] lim);
    return (age >= lim) ? lim : age + 1'b1;
  endfunction

endpackage

// File: rtl/lsu_resp_queue.sv
// In-order response queue for one request type (load or store).
// Each accepted address is stored with an age counter; the head entry is
// popped once LATENCY edges have passed since its acceptance, producing a
// registered one-cycle resp_o pulse carrying its address.
// Ports:
//   clk_i, rst_ni   clock, async active-low reset
//   push_i          request of this type is valid (ignored while full)
//   push_addr_i     address of the request
//   full_o          occupancy == DEPTH (no same-cycle pop credit)
//   resp_o          one-cycle response pulse
//   resp_addr_o     address of the responding entry, 0 when no pulse
//   count_o         current occupancy
module lsu_resp_queue
  import cva6_lsu_mem_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned LATENCY = 3,
  localparam int unsigned PTR_W  = $clog2(DEPTH),
  localparam int unsigned CNT_W  = PTR_W + 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic [ADDR_W-1:0] push_addr_i,
  output logic              full_o,
  output logic              resp_o,
  output logic [ADDR_W-1:0] resp_addr_o,
  output logic [CNT_W-1:0]  count_o
);

  localparam logic [AGE_W-1:0] AGE_LIM  = AGE_W'(LATENCY);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [AGE_W-1:0]  age_q  [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [AGE_W:0]    head_age_nx;
  logic              push;
  logic              pop;

  assign full_o  = (count_q == CNT_FULL);
  assign count_o = count_q;
  assign push    = push_i && !full_o;

  // The head pops on the edge at which its age would reach LATENCY, so the
  // pulse is registered exactly LATENCY edges after acceptance, or one edge
  // after the previous pop when entries are queued behind each other.
  assign head_age_nx = {1'b0, age_q[rd_ptr_q]} + 1'b1;
  assign pop         = (count_q != '0) && (head_age_nx >= {1'b0, AGE_LIM});

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      resp_o      <= 1'b0;
      resp_addr_o <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        age_q[i]  <= '0;
      end
    end else begin
      // Every slot ages; a free slot's age is don't-care and is cleared on push.
      for (int i = 0; i < DEPTH; i++) begin
        age_q[i] <= age_inc(age_q[i], AGE_LIM);
      end
      if (push) begin
        addr_q[wr_ptr_q] <= push_addr_i;
        age_q[wr_ptr_q]  <= '0;
        wr_ptr_q         <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      resp_o      <= pop;
      resp_addr_o <= pop ? addr_q[rd_ptr_q] : '0;
    end
  end

endmodule

// File: rtl/cva6_lsu_mem_responder.sv
// Memory-side responder for the CVA6 LSU request interface.
// Loads and stores are held in independent in-order queues and each returns
// a one-cycle response pulse LATENCY cycles after acceptance (later if the
// queue is backed up).
// Ports:
//   clk_i, rst_ni                         clock, async active-low reset
//   req_valid_i, req_is_load_i, req_addr_i request from the LSU
//   req_ready_o                           selected queue is not full
//   load_mem_resp_o, load_resp_addr_o     load response pulse and address
//   store_mem_resp_o, store_resp_addr_o   store response pulse and address
//   load_pending_o, store_pending_o       queue occupancies
module cva6_lsu_mem_responder
  import cva6_lsu_mem_pkg::*;
#(
  parameter int unsigned LATENCY = 3,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned ADDR_W  = 32,
  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  input  logic              req_is_load_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  output logic              req_ready_o,
  output logic              load_mem_resp_o,
  output logic [ADDR_W-1:0] load_resp_addr_o,
  output logic              store_mem_resp_o,
  output logic [ADDR_W-1:0] store_resp_addr_o,
  output logic [CNT_W-1:0]  load_pending_o,
  output logic [CNT_W-1:0]  store_pending_o
);

  logic load_full;
  logic store_full;

  lsu_resp_queue #(
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W),
    .LATENCY (LATENCY)
  ) u_load_q (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (req_valid_i && req_is_load_i),
    .push_addr_i (req_addr_i),
    .full_o      (load_full),
    .resp_o      (load_mem_resp_o),
    .resp_addr_o (load_resp_addr_o),
    .count_o     (load_pending_o)
  );

  lsu_resp_queue #(
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W),
    .LATENCY (LATENCY)
  ) u_store_q (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (req_valid_i && !req_is_load_i),
    .push_addr_i (req_addr_i),
    .full_o      (store_full),
    .resp_o      (store_mem_resp_o),
    .resp_addr_o (store_resp_addr_o),
    .count_o     (store_pending_o)
  );

  assign req_ready_o = req_is_load_i ? !load_full : !store_full;

`ifndef SYNTHESIS
  logic              chk_stall_q;
  logic [ADDR_W-1:0] chk_addr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      chk_stall_q <= 1'b0;
      chk_addr_q  <= '0;
    end else begin
      chk_stall_q <= req_valid_i && !req_ready_o;
      chk_addr_q  <= req_addr_i;
      if (req_valid_i && $isunknown(req_is_load_i)) begin
        $error("protocol: req_is_load_i unknown while req_valid_i is high");
      end
      if (chk_stall_q && req_valid_i && (req_addr_i !== chk_addr_q)) begin
        $error("protocol: req_addr_i changed while request was stalled");
      end
    end
  end
`endif

endmodule

// File: tb/tb_cva6_lsu_mem_responder.sv
module tb_cva6_lsu_mem_responder;

  localparam int N = 3;
  localparam int LAT [N] = '{3, 1, 5};
  localparam int DEP [N] = '{4, 2, 2};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        v   [N];
  logic        ld  [N];
  logic [31:0] ad  [N];
  logic        rdy [N];
  logic        lr  [N];
  logic        sr  [N];
  logic [31:0] la  [N];
  logic [31:0] sa  [N];
  logic [2:0]  lp  [N];
  logic [2:0]  sp  [N];
  logic [1:0]  lp1, sp1, lp2, sp2;

  assign lp[1] = {1'b0, lp1};
  assign sp[1] = {1'b0, sp1};
  assign lp[2] = {1'b0, lp2};
  assign sp[2] = {1'b0, sp2};

  always #5 clk = ~clk;

  cva6_lsu_mem_responder #(.LATENCY(3), .DEPTH(4), .ADDR_W(32)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(v[0]), .req_is_load_i(ld[0]),
    .req_addr_i(ad[0]), .req_ready_o(rdy[0]), .load_mem_resp_o(lr[0]),
    .load_resp_addr_o(la[0]), .store_mem_resp_o(sr[0]), .store_resp_addr_o(sa[0]),
    .load_pending_o(lp[0]), .store_pending_o(sp[0]));

  cva6_lsu_mem_responder #(.LATENCY(1), .DEPTH(2), .ADDR_W(32)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(v[1]), .req_is_load_i(ld[1]),
    .req_addr_i(ad[1]), .req_ready_o(rdy[1]), .load_mem_resp_o(lr[1]),
    .load_resp_addr_o(la[1]), .store_mem_resp_o(sr[1]), .store_resp_addr_o(sa[1]),
    .load_pending_o(lp1), .store_pending_o(sp1));

  cva6_lsu_mem_responder #(.LATENCY(5), .DEPTH(2), .ADDR_W(32)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(v[2]), .req_is_load_i(ld[2]),
    .req_addr_i(ad[2]), .req_ready_o(rdy[2]), .load_mem_resp_o(lr[2]),
    .load_resp_addr_o(la[2]), .store_mem_resp_o(sr[2]), .store_resp_addr_o(sa[2]),
    .load_pending_o(lp2), .store_pending_o(sp2));

  // Reference model: per instance and per type (1 = load, 0 = store), a FIFO
  // of outstanding requests, each tagged with the edge number it must respond on.
  typedef struct {
    logic [31:0] addr;
    int          due;
  } ent_t;

  ent_t mq [N][2][$];
  int   last_due [N][2];
  logic acc_q [N];
  int   edge_n = 0;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input int inst, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d edge %0d: got %h expected %h", nm, inst, edge_n, act, exp);
    end
  endtask

  // One clock cycle: entered at a negedge with inputs applied, returns at the
  // next negedge with outputs of the intervening posedge checked.
  task automatic step();
    logic        er;
    int          t;
    int          d;
    ent_t        e;
    logic        exp_r [N][2];
    logic [31:0] exp_a [N][2];
    #1;
    for (int i = 0; i < N; i++) begin
      t  = ld[i] ? 1 : 0;
      er = (mq[i][t].size() < DEP[i]);
      chk("ready", i, {31'b0, rdy[i]}, {31'b0, er});
      acc_q[i] = v[i] && er;
    end
    @(posedge clk);
    edge_n++;
    for (int i = 0; i < N; i++) begin
      for (int tt = 0; tt < 2; tt++) begin
        exp_r[i][tt] = 1'b0;
        exp_a[i][tt] = '0;
        if (mq[i][tt].size() > 0 && mq[i][tt][0].due == edge_n) begin
          exp_r[i][tt] = 1'b1;
          exp_a[i][tt] = mq[i][tt][0].addr;
          void'(mq[i][tt].pop_front());
        end
      end
      if (acc_q[i]) begin
        t = ld[i] ? 1 : 0;
        d = edge_n + LAT[i];
        if (last_due[i][t] + 1 > d) d = last_due[i][t] + 1;
        e.addr = ad[i];
        e.due  = d;
        mq[i][t].push_back(e);
        last_due[i][t] = d;
      end
    end
    #1;
    for (int i = 0; i < N; i++) begin
      chk("load_resp", i, {31'b0, lr[i]}, {31'b0, exp_r[i][1]});
      chk("load_addr", i, la[i], exp_a[i][1]);
      chk("store_resp", i, {31'b0, sr[i]}, {31'b0, exp_r[i][0]});
      chk("store_addr", i, sa[i], exp_a[i][0]);
      chk("load_pending", i, {29'b0, lp[i]}, 32'(mq[i][1].size()));
      chk("store_pending", i, {29'b0, sp[i]}, 32'(mq[i][0].size()));
    end
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string nm);
    for (int i = 0; i < N; i++) begin
      chk({nm, "_lr"}, i, {31'b0, lr[i]}, 32'd0);
      chk({nm, "_la"}, i, la[i], 32'd0);
      chk({nm, "_sr"}, i, {31'b0, sr[i]}, 32'd0);
      chk({nm, "_sa"}, i, sa[i], 32'd0);
      chk({nm, "_lp"}, i, {29'b0, lp[i]}, 32'd0);
      chk({nm, "_sp"}, i, {29'b0, sp[i]}, 32'd0);
      chk({nm, "_rdy"}, i, {31'b0, rdy[i]}, 32'd1);
    end
  endtask

  task automatic flush_model();
    for (int i = 0; i < N; i++) begin
      for (int t = 0; t < 2; t++) begin
        mq[i][t].delete();
        last_due[i][t] = 0;
      end
      v[i]     = 1'b0;
      acc_q[i] = 1'b0;
    end
  endtask

  // Entered at a negedge; asserts reset mid-cycle and releases it at a later negedge.
  task automatic mid_reset();
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    flush_model();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // A stalled request is held unchanged; otherwise draw a new one.
  task automatic gen(input int i, input int pct);
    if (v[i] && !acc_q[i]) return;
    v[i]  = ($urandom_range(0, 99) < pct);
    ld[i] = 1'($urandom_range(0, 1));
    ad[i] = $urandom;
  endtask

  task automatic idle_all();
    for (int i = 0; i < N; i++) v[i] = 1'b0;
  endtask

  initial begin
    int n;
    for (int i = 0; i < N; i++) begin
      v[i] = 1'b0; ld[i] = 1'b0; ad[i] = '0;
    end
    flush_model();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Single load 0xcad: pulse exactly three edges after acceptance.
    v[0] = 1'b1; ld[0] = 1'b1; ad[0] = 32'hcad;
    step();
    chk("t1_pending_after_accept", 0, {29'b0, lp[0]}, 32'd1);
    idle_all();
    step();
    step();
    chk("t1_no_early_pulse", 0, {31'b0, lr[0]}, 32'd0);
    step();
    chk("t1_pulse", 0, {31'b0, lr[0]}, 32'd1);
    chk("t1_pulse_addr", 0, la[0], 32'hcad);
    chk("t1_no_store", 0, {31'b0, sr[0]}, 32'd0);
    step();
    chk("t1_single_cycle", 0, {31'b0, lr[0]}, 32'd0);

    // Load 0xa then store 0xb on consecutive edges: independent pulses.
    v[0] = 1'b1; ld[0] = 1'b1; ad[0] = 32'ha;
    step();
    ld[0] = 1'b0; ad[0] = 32'hb;
    step();
    idle_all();
    step();
    step();
    chk("t3_load_pulse", 0, {31'b0, lr[0]}, 32'd1);
    chk("t3_load_addr", 0, la[0], 32'ha);
    step();
    chk("t3_store_pulse", 0, {31'b0, sr[0]}, 32'd1);
    chk("t3_store_addr", 0, sa[0], 32'hb);
    step();

    // LATENCY=1, DEPTH=2: a store every cycle gives a pulse every cycle.
    for (int j = 0; j < 6; j++) begin
      v[1] = 1'b1; ld[1] = 1'b0; ad[1] = 32'h100 + 32'(j);
      step();
      chk("t6_pending_le1", 1, {31'b0, (sp[1] <= 3'd1)}, 32'd1);
      if (j >= 1) begin
        chk("t6_pulse", 1, {31'b0, sr[1]}, 32'd1);
        chk("t6_addr", 1, sa[1], 32'h100 + 32'(j - 1));
      end
    end
    idle_all();
    step();
    chk("t6_last_addr", 1, sa[1], 32'h105);

    // LATENCY=5, DEPTH=2: third load is refused until the head pops.
    v[2] = 1'b1; ld[2] = 1'b1; ad[2] = 32'h200;
    step();
    ad[2] = 32'h204;
    step();
    ad[2] = 32'h208;
    n = 0;
    do begin
      step();
      n++;
      chk("full_pending_le2", 2, {31'b0, (lp[2] <= 3'd2)}, 32'd1);
    end while (!acc_q[2] && n < 20);
    chk("full_wait_cycles", 2, n, 32'd5);
    idle_all();
    repeat (12) step();

    // Reset with three loads in flight: nothing may come out afterwards.
    v[0] = 1'b1; ld[0] = 1'b1;
    for (int j = 0; j < 3; j++) begin
      ad[0] = 32'h300 + 32'(j);
      step();
    end
    idle_all();
    mid_reset();
    for (int j = 0; j < 8; j++) begin
      step();
      chk("t4_no_resp_after_reset", 0, {31'b0, lr[0]}, 32'd0);
    end

    // Random traffic, heavy then light, with one reset in the middle.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) gen(i, (c < 1500) ? 85 : 40);
      step();
      if (c == 1500) mid_reset();
    end
    idle_all();
    repeat (40) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
